// File: rtl/branch_redirect_unit_pkg.sv
// Shared constants for the branch redirect unit: FSM state encodings,
// PC increment and default sizing.
package branch_redirect_unit_pkg;

    localparam int WORD_LEN_DEF     = 32;
    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int PC_INC           = 4;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSHING = 2'd1;
    localparam logic [1:0] ST_PENDING  = 2'd2;

endpackage

// File: rtl/branch_redirect_unit_flush_timer.sv
// redirect_flush_timer: loadable 3-bit down-counter. Active while non-zero,
// which is what drives FLUSH; o_last marks the final flush cycle so the
// FSM can return to RUN on the following edge.
module redirect_flush_timer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [2:0] i_load_value,
    input  logic       i_tick,
    output logic       o_active,
    output logic       o_last
);

    logic [2:0] r_count;

    // Load takes priority; otherwise count down to zero and stop there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 3'd0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_tick && (r_count != 3'd0)) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign o_active = (r_count != 3'd0);
    assign o_last   = (r_count == 3'd1);

endmodule

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: owns the fetch PC, applies taken-branch redirects,
// kills wrong-path IF/ID slots for FLUSH_CYCLES cycles and defers a
// redirect that arrives while the front end is frozen.
//
// Optional feature macro: BRANCH_REDIRECT_STATS_EN adds saturating
// o_taken_count / o_ignored_count statistics outputs.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_RUN      | normal sequential fetch, redirects accepted
// ST_FLUSHING | redirect applied, wrong-path slots being killed
// ST_PENDING  | redirect latched during freeze, waiting for release
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int                  WORD_LEN     = WORD_LEN_DEF,
    parameter int                  FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter logic [WORD_LEN-1:0] PC_RESET     = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_freeze,
    input  logic                i_branch_condition,
    input  logic [WORD_LEN-1:0] i_branch_target,
    output logic [WORD_LEN-1:0] o_pc,
    output logic [WORD_LEN-1:0] o_pc_plus4,
    output logic                o_flush,
`ifdef BRANCH_REDIRECT_STATS_EN
    output logic [15:0]         o_taken_count,
    output logic [15:0]         o_ignored_count,
`endif
    output logic                o_redirect_pending
);

    localparam logic [WORD_LEN-1:0] ALIGN_MASK = ~WORD_LEN'(3);
    localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]          r_state;
    logic [WORD_LEN-1:0] r_pc;
    logic [WORD_LEN-1:0] r_pending_target;
    logic                r_redirect_pending;

    logic [1:0]          w_state_nxt;
    logic [WORD_LEN-1:0] w_pc_nxt;
    logic [WORD_LEN-1:0] w_pending_nxt;
    logic                w_redirect_pending_nxt;
    logic [WORD_LEN-1:0] w_aligned_target;
    logic [WORD_LEN-1:0] w_pc_plus4;
    logic                w_timer_load;
    logic                w_timer_active;
    logic                w_timer_last;

    assign w_aligned_target = i_branch_target & ALIGN_MASK;
    assign w_pc_plus4       = r_pc + WORD_LEN'(PC_INC);

    // Flush window timer; it keeps counting through frozen cycles.
    redirect_flush_timer u_flush_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_timer_load),
        .i_load_value (FLUSH_LOAD),
        .i_tick       (1'b1),
        .o_active     (w_timer_active),
        .o_last       (w_timer_last)
    );

    // Next-state, next-PC and pending-target selection.
    always_comb begin
        w_state_nxt            = r_state;
        w_pc_nxt               = r_pc;
        w_pending_nxt          = r_pending_target;
        w_redirect_pending_nxt = r_redirect_pending;
        w_timer_load           = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_branch_condition) begin
                    if (!i_freeze) begin
                        w_pc_nxt     = w_aligned_target;
                        w_state_nxt  = ST_FLUSHING;
                        w_timer_load = 1'b1;
                    end else begin
                        w_pending_nxt          = w_aligned_target;
                        w_redirect_pending_nxt = 1'b1;
                        w_state_nxt            = ST_PENDING;
                    end
                end else if (!i_freeze) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
            ST_PENDING: begin
                // Later requests come from younger instructions; the first
                // latched target wins.
                if (!i_freeze) begin
                    w_pc_nxt               = r_pending_target;
                    w_redirect_pending_nxt = 1'b0;
                    w_state_nxt            = ST_FLUSHING;
                    w_timer_load           = 1'b1;
                end
            end
            ST_FLUSHING: begin
                // Branch requests here belong to killed wrong-path slots.
                if (!i_freeze) begin
                    w_pc_nxt = w_pc_plus4;
                end
                if (w_timer_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state            <= ST_RUN;
            r_pc               <= PC_RESET;
            r_pending_target   <= '0;
            r_redirect_pending <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_pc               <= w_pc_nxt;
            r_pending_target   <= w_pending_nxt;
            r_redirect_pending <= w_redirect_pending_nxt;
        end
    end

`ifdef BRANCH_REDIRECT_STATS_EN
    logic        w_accept;
    logic        w_ignore;
    logic [15:0] r_taken_count;
    logic [15:0] r_ignored_count;

    assign w_accept = (r_state == ST_RUN) && i_branch_condition;
    assign w_ignore = (r_state != ST_RUN) && i_branch_condition;

    // Saturating counters of accepted and discarded redirect requests.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_taken_count   <= 16'd0;
            r_ignored_count <= 16'd0;
        end else begin
            if (w_accept && (r_taken_count != 16'hFFFF)) begin
                r_taken_count <= r_taken_count + 16'd1;
            end
            if (w_ignore && (r_ignored_count != 16'hFFFF)) begin
                r_ignored_count <= r_ignored_count + 16'd1;
            end
        end
    end

    assign o_taken_count   = r_taken_count;
    assign o_ignored_count = r_ignored_count;
`endif

    assign o_pc               = r_pc;
    assign o_pc_plus4         = w_pc_plus4;
    assign o_flush            = w_timer_active;
    assign o_redirect_pending = r_redirect_pending;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed testbench for branch_redirect_unit: expectations are queued as
// each step is driven and popped/compared one cycle later.
module tb_branch_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        bc;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        rpend;
`ifdef BRANCH_REDIRECT_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] ignored_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        fl;
        logic        rp;
    } exp_t;

    exp_t sb[$];

    branch_redirect_unit #(
        .WORD_LEN     (32),
        .FLUSH_CYCLES (2),
        .PC_RESET     (32'h0040_0000)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_freeze           (freeze),
        .i_branch_condition (bc),
        .i_branch_target    (target),
        .o_pc               (pc),
        .o_pc_plus4         (pc_plus4),
        .o_flush            (flush),
`ifdef BRANCH_REDIRECT_STATS_EN
        .o_taken_count      (taken_cnt),
        .o_ignored_count    (ignored_cnt),
`endif
        .o_redirect_pending (rpend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] epc,
                              input logic efl, input logic erp);
        sb.push_back('{tag, epc, efl, erp});
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, "_pc"}, pc, e.pc);
            cmp({e.tag, "_pc4"}, pc_plus4, e.pc + 32'd4);
            cmp({e.tag, "_flush"}, {31'd0, flush}, {31'd0, e.fl});
            cmp({e.tag, "_pend"}, {31'd0, rpend}, {31'd0, e.rp});
        end
    endtask

    // Drive one cycle of inputs, queue what must be visible after the edge.
    task automatic step(input logic ibc, input logic [31:0] itgt, input logic ifrz,
                        input string tag, input logic [31:0] epc,
                        input logic efl, input logic erp);
        bc     = ibc;
        target = itgt;
        freeze = ifrz;
        expect_now(tag, epc, efl, erp);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst_n  = 1'b0;
        freeze = 1'b0;
        bc     = 1'b0;
        target = 32'd0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        expect_now("rst", 32'h0040_0000, 1'b0, 1'b0);
        check_out();
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0, "seq1", 32'h0040_0004, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, "seq2", 32'h0040_0008, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        expect_now("arst", 32'h0040_0000, 1'b0, 1'b0);
        check_out();
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0, "arst_rel", 32'h0040_0004, 1'b0, 1'b0);

        // Frozen RUN holds PC.
        step(1'b0, 32'd0, 1'b1, "hold", 32'h0040_0004, 1'b0, 1'b0);

        // Move to PC=0x10 via a redirect to 0x8.
        step(1'b1, 32'h0000_0008, 1'b0, "to8", 32'h0000_0008, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "to8_f", 32'h0000_000C, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "to8_e", 32'h0000_0010, 1'b0, 1'b0);

        // Basic redirect with unaligned target.
        step(1'b1, 32'h0000_0103, 1'b0, "br", 32'h0000_0100, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "br_f", 32'h0000_0104, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "br_e", 32'h0000_0108, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, "br_run", 32'h0000_010C, 1'b0, 1'b0);

        // Request during the flush is ignored.
        step(1'b1, 32'h0000_0400, 1'b0, "br2", 32'h0000_0400, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0200, 1'b0, "ign", 32'h0000_0404, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "ign_e", 32'h0000_0408, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, "ign_run", 32'h0000_040C, 1'b0, 1'b0);

        // Frozen redirect, later requests while pending are discarded.
        step(1'b1, 32'h0000_0300, 1'b1, "frz0", 32'h0000_040C, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0500, 1'b1, "frz1", 32'h0000_040C, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0500, 1'b1, "frz2", 32'h0000_040C, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0500, 1'b1, "frz3", 32'h0000_040C, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, "rel", 32'h0000_0300, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "rel_f", 32'h0000_0304, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "rel_e", 32'h0000_0308, 1'b0, 1'b0);

        // Flush counter keeps running while frozen.
        step(1'b1, 32'h0000_0600, 1'b0, "ff", 32'h0000_0600, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, "ff_frz", 32'h0000_0600, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "ff_e", 32'h0000_0604, 1'b0, 1'b0);

        // Wrap-around and back-to-back redirect.
        step(1'b1, 32'hFFFF_FFFE, 1'b0, "wrap", 32'hFFFF_FFFC, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "wrap0", 32'h0000_0000, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "wrap4", 32'h0000_0004, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0040, 1'b0, "b2b", 32'h0000_0040, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "b2b_f", 32'h0000_0044, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, "b2b_e", 32'h0000_0048, 1'b0, 1'b0);

`ifdef BRANCH_REDIRECT_STATS_EN
        cmp("taken_cnt", {16'd0, taken_cnt}, 32'd7);
        cmp("ignored_cnt", {16'd0, ignored_cnt}, 32'd4);
`endif

        // Reset while a redirect is pending abandons it.
        step(1'b1, 32'h0000_0700, 1'b1, "pend", 32'h0000_0048, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        expect_now("pend_rst", 32'h0040_0000, 1'b0, 1'b0);
        check_out();
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0, "pend_gone", 32'h0040_0004, 1'b0, 1'b0);

`ifdef BRANCH_REDIRECT_STATS_EN
        cmp("taken_rst", {16'd0, taken_cnt}, 32'd0);
        cmp("ignored_rst", {16'd0, ignored_cnt}, 32'd0);
        // Sit in PENDING with the request held to saturate the ignore count.
        bc     = 1'b1;
        target = 32'h0000_0800;
        freeze = 1'b1;
        repeat (70001) @(posedge clk);
        #1;
        cmp("ignored_sat", {16'd0, ignored_cnt}, 32'h0000_FFFF);
        cmp("taken_sat", {16'd0, taken_cnt}, 32'd1);
        cmp("sat_pend", {31'd0, rpend}, 32'd1);
        bc     = 1'b0;
        freeze = 1'b0;
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_left: observed=%0d expected=0 entries", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
